// File: rtl/gh_uart_rx_ctrl_pkg.sv
// Shared types for the UART receive controller: capture-FSM encoding, FIFO entry layout
// and the trigger-level lookup.
package gh_uart_rx_ctrl_pkg;

  typedef logic [1:0] cap_state_t;

  localparam cap_state_t CAP_IDLE = 2'd0;
  localparam cap_state_t CAP_PUSH = 2'd1;
  localparam cap_state_t CAP_WAIT = 2'd2;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } rx_entry_t;

  function automatic int trig_level(input logic [1:0] sel, input int depth);
    case (sel)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/gh_uart_rx_ctrl_if.sv
// Bundle between the receive controller, the Rx core (character side) and the
// register-file decode (host side).
interface gh_uart_rx_ctrl_if #(
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]       rx_d;
  logic             rx_d_rdy;
  logic             rx_pe;
  logic             rx_fe;
  logic             rx_bi;
  logic             fifo_clr;
  logic             rd;
  logic             lsr_rd;

  logic [7:0]       rd_data;
  logic [4:0]       lsr;
  logic             dr;
  logic [CNT_W-1:0] count;
  logic             rda_itr;
  logic             rls_itr;
  logic             tmo_itr;

  modport slave (
    input  rx_d, rx_d_rdy, rx_pe, rx_fe, rx_bi, fifo_clr, rd, lsr_rd,
    output rd_data, lsr, dr, count, rda_itr, rls_itr, tmo_itr
  );

  modport master (
    output rx_d, rx_d_rdy, rx_pe, rx_fe, rx_bi, fifo_clr, rd, lsr_rd,
    input  rd_data, lsr, dr, count, rda_itr, rls_itr, tmo_itr
  );

endinterface

// File: rtl/gh_uart_rx_fifo.sv
// DEPTH-entry synchronous FIFO of received characters with their error flags.
// Pop is taken before push, so a push into a full FIFO succeeds when a pop lands on the same clock.
module gh_uart_rx_fifo
  import gh_uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        clr_i,
  input  rx_entry_t                   wdata_i,
  output rx_entry_t                   rdata_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(DEPTH):0]      count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  rx_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PTR_ONE;
      if (rd_en) rptr_q <= rptr_q + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i && !clr_i && wr_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gh_uart_rx_ctrl.sv
// UART receive controller: one push per Rx-core character, line status, RDA/RLS interrupts.
// Define GH_UART_RX_TIMEOUT_EN to build the character-timeout counter and tmo_itr.
//   state    | meaning
//   CAP_IDLE | waiting for rx_d_rdy
//   CAP_PUSH | writing the character into the FIFO this clock
//   CAP_WAIT | character taken, waiting for rx_d_rdy to drop
module gh_uart_rx_ctrl
  import gh_uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               brcx16_i,
  input  logic [3:0]         num_bits_i,
  input  logic               parity_en_i,
  input  logic [1:0]         trig_sel_i,
  gh_uart_rx_ctrl_if.slave   rx_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  cap_state_t       state_q, state_d;
  rx_entry_t        wentry, head;
  logic             push, pop, push_ok, full, empty;
  logic             entry_err, head_err;
  logic             oe_q, oe_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, count, trig_lvl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CAP_IDLE: if (rx_if.rx_d_rdy) state_d = CAP_PUSH;
      CAP_PUSH: state_d = CAP_WAIT;
      CAP_WAIT: if (!rx_if.rx_d_rdy) state_d = CAP_IDLE;
      default:  state_d = CAP_IDLE;
    endcase
  end

  assign push      = (state_q == CAP_PUSH);
  assign pop       = rx_if.rd && !empty;
  assign push_ok   = push && (!full || pop);
  assign wentry    = {rx_if.rx_bi, rx_if.rx_fe, rx_if.rx_pe, rx_if.rx_d};
  assign entry_err = wentry.bi | wentry.fe | wentry.pe;
  assign head_err  = head.bi | head.fe | head.pe;

  gh_uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .pop_i   (rx_if.rd),
    .clr_i   (rx_if.fifo_clr),
    .wdata_i (wentry),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Overrun set beats an LSR-read clear; a flush clears regardless.
  always_comb begin
    oe_d      = oe_q;
    err_cnt_d = err_cnt_q;
    if (rx_if.fifo_clr) begin
      oe_d      = 1'b0;
      err_cnt_d = '0;
    end else begin
      if (push && full && !pop) oe_d = 1'b1;
      else if (rx_if.lsr_rd)    oe_d = 1'b0;
      case ({push_ok && entry_err, pop && head_err})
        2'b10:   err_cnt_d = err_cnt_q + CNT_ONE;
        2'b01:   err_cnt_d = err_cnt_q - CNT_ONE;
        default: err_cnt_d = err_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= CAP_IDLE;
      oe_q      <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      oe_q      <= oe_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign trig_lvl      = CNT_W'(trig_level(trig_sel_i, DEPTH));
  assign rx_if.rd_data = head.d;
  assign rx_if.lsr     = {err_cnt_q != '0, head.bi, head.fe, head.pe, oe_q};
  assign rx_if.dr      = !empty;
  assign rx_if.count   = count;
  assign rx_if.rda_itr = (count >= trig_lvl);
  assign rx_if.rls_itr = oe_q | head_err;

`ifdef GH_UART_RX_TIMEOUT_EN
  logic [9:0] tmo_q, tmo_d, tmo_lim;
  logic [3:0] char_bits;

  // Four characters of 16 ticks per bit: 64 * (data + parity + start + stop).
  assign char_bits = num_bits_i + {3'b000, parity_en_i} + 4'd2;
  assign tmo_lim   = {char_bits, 6'b000000};

  always_comb begin
    tmo_d = tmo_q;
    if (push || pop || rx_if.fifo_clr || empty) tmo_d = '0;
    else if (brcx16_i && (tmo_q < tmo_lim))     tmo_d = tmo_q + 10'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end

  assign rx_if.tmo_itr = (tmo_q >= tmo_lim);
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^{brcx16_i, num_bits_i, parity_en_i};
  assign rx_if.tmo_itr  = 1'b0;
`endif

endmodule

// File: tb/tb_gh_uart_rx_ctrl.sv
// Bench for gh_uart_rx_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized character traffic.
module tb_gh_uart_rx_ctrl;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       brcx16 = 1'b0;
  logic [3:0] num_bits = 4'd8;
  logic       parity_en = 1'b0;
  logic [1:0] trig_sel = 2'd0;

  gh_uart_rx_ctrl_if #(.DEPTH(DEPTH)) rx_if ();

  gh_uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .brcx16_i    (brcx16),
    .num_bits_i  (num_bits),
    .parity_en_i (parity_en),
    .trig_sel_i  (trig_sel),
    .rx_if       (rx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries are {bi, fe, pe, d}.
  logic [10:0] q[$];
  bit          m_oe = 0;
  int          m_ticks = 0;
  bit          p1 = 0, p2 = 0;
  bit          m_valid = 0;

  always @(posedge clk) begin
    bit pushev, popped, oe_set;
    int sz0;
    if (!rst_n) begin
      q.delete();
      m_oe = 0; m_ticks = 0; p1 = 0; p2 = 0; m_valid = 1;
    end else begin
      // A character is taken on the clock after d_rdy is first seen high.
      pushev = p1 && !p2;
      p2 = p1;
      p1 = rx_if.rx_d_rdy;
      sz0 = q.size();
      popped = rx_if.rd && (sz0 > 0);
      if (rx_if.fifo_clr) begin
        q.delete();
        m_oe = 0;
        m_ticks = 0;
      end else begin
        oe_set = 0;
        if (popped) void'(q.pop_front());
        if (pushev) begin
          if (q.size() < DEPTH) q.push_back({rx_if.rx_bi, rx_if.rx_fe, rx_if.rx_pe, rx_if.rx_d});
          else oe_set = 1;
        end
        if (oe_set) m_oe = 1;
        else if (rx_if.lsr_rd) m_oe = 0;
        if (pushev || popped || sz0 == 0) m_ticks = 0;
        else if (brcx16) m_ticks++;
      end
    end
  end

  always @(negedge clk) begin
    logic [10:0] h;
    bit ferr, te;
    int tl;
    if (m_valid) begin
      h = (q.size() > 0) ? q[0] : 11'd0;
      ferr = 0;
      foreach (q[i]) if (|q[i][10:8]) ferr = 1;
      case (trig_sel)
        2'd0: tl = 1;
        2'd1: tl = 4;
        2'd2: tl = 8;
        default: tl = DEPTH - 2;
      endcase
`ifdef GH_UART_RX_TIMEOUT_EN
      te = (m_ticks >= 64 * (int'(num_bits) + int'(parity_en) + 2));
`else
      te = 0;
`endif
      chk("count",   32'(rx_if.count), 32'(q.size()));
      chk("dr",      32'(rx_if.dr), 32'(q.size() != 0));
      chk("rd_data", 32'(rx_if.rd_data), 32'(h[7:0]));
      chk("lsr",     32'(rx_if.lsr), 32'({ferr, h[10:8], m_oe}));
      chk("rda_itr", 32'(rx_if.rda_itr), 32'(q.size() >= tl));
      chk("rls_itr", 32'(rx_if.rls_itr), 32'(m_oe | (|h[10:8])));
      chk("tmo_itr", 32'(rx_if.tmo_itr), 32'(te));
    end
  end

  int rd_pct = 0, lsr_pct = 0, clr_pct = 0;
  int brc_mode = 2;  // 0 random, 1 always, 2 never

  task automatic step(input bit r, input bit l, input bit c);
    @(negedge clk);
    rx_if.rd = r;
    rx_if.lsr_rd = l;
    rx_if.fifo_clr = c;
    case (brc_mode)
      0: brcx16 = ($urandom_range(3) == 0);
      1: brcx16 = 1'b1;
      default: brcx16 = 1'b0;
    endcase
  endtask

  task automatic rstep();
    step($urandom_range(99) < rd_pct, $urandom_range(99) < lsr_pct, $urandom_range(99) < clr_pct);
  endtask

  task automatic send_char(input logic [7:0] d, input bit pe, input bit fe, input bit bi,
                           input int hold, input int gap, input bit rdp, input bit clrp, input bit rnd);
    for (int i = 0; i < hold; i++) begin
      if (rnd) rstep();
      else step(i == 1 && rdp, 1'b0, i == 1 && clrp);
      if (i == 0) begin
        rx_if.rx_d = d; rx_if.rx_pe = pe; rx_if.rx_fe = fe; rx_if.rx_bi = bi;
        rx_if.rx_d_rdy = 1'b1;
      end
    end
    for (int i = 0; i < gap; i++) begin
      if (rnd) rstep();
      else step(1'b0, 1'b0, 1'b0);
      if (i == 0) rx_if.rx_d_rdy = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] d);
    send_char(d, 0, 0, 0, 4, 1, 0, 0, 0);
  endtask

  task automatic pop1();
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic set_cfg(input logic [1:0] ts, input logic [3:0] nb, input logic pen);
    @(posedge clk);
    #1;
    trig_sel = ts; num_bits = nb; parity_en = pen;
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  initial begin
    rx_if.rx_d = 8'h00; rx_if.rx_d_rdy = 1'b0;
    rx_if.rx_pe = 1'b0; rx_if.rx_fe = 1'b0; rx_if.rx_bi = 1'b0;
    rx_if.rd = 1'b0; rx_if.lsr_rd = 1'b0; rx_if.fifo_clr = 1'b0;

    repeat (3) step(0, 0, 0);
    chk("rst_count", 32'(rx_if.count), 0);
    chk("rst_dr", 32'(rx_if.dr), 0);
    chk("rst_rd_data", 32'(rx_if.rd_data), 0);
    chk("rst_lsr", 32'(rx_if.lsr), 0);
    chk("rst_itr", 32'({rx_if.rda_itr, rx_if.rls_itr, rx_if.tmo_itr}), 0);
    rst_n = 1'b1;

    // Three characters, d_rdy held 16 clocks each
    send_char(8'h41, 0, 0, 0, 16, 2, 0, 0, 0);
    send_char(8'h42, 0, 0, 0, 16, 2, 0, 0, 0);
    send_char(8'h43, 0, 0, 0, 16, 2, 0, 0, 0);
    chk("t1_count", 32'(rx_if.count), 3);
    chk("t1_pop0", 32'(rx_if.rd_data), 32'h41);
    pop1(); chk("t1_pop1", 32'(rx_if.rd_data), 32'h42);
    pop1(); chk("t1_pop2", 32'(rx_if.rd_data), 32'h43);
    pop1(); chk("t1_empty", 32'(rx_if.count), 0);
    pop1(); chk("t1_pop_empty", 32'(rx_if.count), 0);

    // Trigger level 4
    set_cfg(2'd1, 4'd8, 1'b0);
    send(8'h01); send(8'h02); send(8'h03);
    chk("t2_rda_at3", 32'(rx_if.rda_itr), 0);
    send(8'h04);
    chk("t2_rda_at4", 32'(rx_if.rda_itr), 1);
    pop1(); chk("t2_rda_after_rd", 32'(rx_if.rda_itr), 0);
    step(0, 0, 1); step(0, 0, 0);
    chk("t2_clr", 32'(rx_if.count), 0);

    // Overrun
    set_cfg(2'd0, 4'd8, 1'b0);
    for (int i = 0; i < DEPTH; i++) send(8'(8'h80 + i));
    chk("t3_full", 32'(rx_if.count), 16);
    send(8'h55);
    chk("t3_oe_set", 32'(rx_if.lsr[0]), 1);
    chk("t3_count", 32'(rx_if.count), 16);
    chk("t3_head", 32'(rx_if.rd_data), 32'h80);
    step(0, 1, 0); step(0, 0, 0);
    chk("t3_oe_clr", 32'(rx_if.lsr[0]), 0);
    send_char(8'h66, 0, 0, 0, 4, 1, 1, 0, 0);
    chk("t3_rdpush_oe", 32'(rx_if.lsr[0]), 0);
    chk("t3_rdpush_count", 32'(rx_if.count), 16);
    chk("t3_rdpush_head", 32'(rx_if.rd_data), 32'h81);

    // Errored entry behind a clean one
    step(0, 0, 1); step(0, 0, 0);
    send(8'h10);
    send_char(8'h00, 0, 0, 1, 4, 1, 0, 0, 0);
    chk("t4_fifo_err", 32'(rx_if.lsr[4]), 1);
    chk("t4_bi_head0", 32'(rx_if.lsr[3]), 0);
    pop1();
    chk("t4_bi_head1", 32'(rx_if.lsr[3]), 1);
    chk("t4_rls", 32'(rx_if.rls_itr), 1);
    pop1();
    chk("t4_fifo_err_clr", 32'(rx_if.lsr[4]), 0);

`ifdef GH_UART_RX_TIMEOUT_EN
    // Timeout at exactly 640 ticks for 8N1
    send(8'h5A);
    brc_mode = 1;
    repeat (639) step(0, 0, 0);
    brc_mode = 2;
    step(0, 0, 0);
    chk("t5_tmo_639", 32'(rx_if.tmo_itr), 0);
    brc_mode = 1;
    step(0, 0, 0);
    brc_mode = 2;
    step(0, 0, 0);
    chk("t5_tmo_640", 32'(rx_if.tmo_itr), 1);
    pop1();
    chk("t5_tmo_rd", 32'(rx_if.tmo_itr), 0);
`endif

    // Flush coincident with a push
    step(0, 0, 1); step(0, 0, 0);
    for (int i = 0; i < 5; i++) send(8'(8'h20 + i));
    send_char(8'h77, 0, 0, 0, 16, 2, 0, 1, 0);
    chk("t6_clr_count", 32'(rx_if.count), 0);
    chk("t6_clr_dr", 32'(rx_if.dr), 0);
    chk("t6_clr_oe", 32'(rx_if.lsr[0]), 0);
    send(8'h31); send(8'h32); send(8'h33);
    step(0, 0, 0);
    rst_n = 1'b0;
    step(0, 0, 0);
    chk("t6_rst_count", 32'(rx_if.count), 0);
    chk("t6_rst_rd_data", 32'(rx_if.rd_data), 0);
    chk("t6_rst_lsr", 32'(rx_if.lsr), 0);
    chk("t6_rst_dr", 32'(rx_if.dr), 0);
    rst_n = 1'b1;

    // Randomized traffic
    for (int blk = 0; blk < 10; blk++) begin
      set_cfg(2'($urandom), 4'(5 + $urandom_range(3)), 1'($urandom));
      step(0, 0, 1);
      case (blk % 3)
        0: rd_pct = 5;
        1: rd_pct = 20;
        default: rd_pct = 50;
      endcase
      lsr_pct = 10; clr_pct = 1; brc_mode = 0;
      repeat (30)
        send_char(8'($urandom), $urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
                  $urandom_range(20, 2), $urandom_range(6, 1), 0, 0, 1);
    end

    // Idle with data held so the timeout can expire under random ticks
    rd_pct = 0; lsr_pct = 0; clr_pct = 0; brc_mode = 2;
    step(0, 0, 1);
    send(8'hC3);
    brc_mode = 0;
    repeat (3200) rstep();
    brc_mode = 2;
    step(0, 0, 0);

    summary();
    $finish;
  end

endmodule
